// File: rtl/serial_link_pwr_seq_pkg.sv
// Shared types for the serial link power/isolation sequencer: FSM states and
// the per-state (isolate, clk_ena, reset_n) control tuple.
package serial_link_pwr_seq_pkg;

  typedef enum logic [2:0] {
    DOWN,
    CLK_ON,
    RST_REL,
    DEISO,
    UP,
    ISO,
    RST_ASSERT
  } pwr_state_e;

  typedef struct packed {
    logic isolate;
    logic clk_ena;
    logic reset_n;
  } pwr_ctrl_t;

  function automatic pwr_ctrl_t pwr_decode(pwr_state_e s);
    pwr_ctrl_t c;
    unique case (s)
      DOWN:       c = '{isolate: 1'b1, clk_ena: 1'b0, reset_n: 1'b0};
      CLK_ON:     c = '{isolate: 1'b1, clk_ena: 1'b1, reset_n: 1'b0};
      RST_REL:    c = '{isolate: 1'b1, clk_ena: 1'b1, reset_n: 1'b1};
      DEISO:      c = '{isolate: 1'b0, clk_ena: 1'b1, reset_n: 1'b1};
      UP:         c = '{isolate: 1'b0, clk_ena: 1'b1, reset_n: 1'b1};
      ISO:        c = '{isolate: 1'b1, clk_ena: 1'b1, reset_n: 1'b1};
      RST_ASSERT: c = '{isolate: 1'b1, clk_ena: 1'b1, reset_n: 1'b0};
      default:    c = '{isolate: 1'b1, clk_ena: 1'b0, reset_n: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_link_pwr_seq.sv
// Serial link power sequencer: brings the link up/down in a fixed handshaked
// order (clock, reset, isolation) from a single level request.
module serial_link_pwr_seq
  import serial_link_pwr_seq_pkg::*;
#(
  parameter int unsigned NumIsoPorts   = 2,
  parameter int unsigned ResetCycles   = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   link_up_req_i,
  input  logic [NumIsoPorts-1:0] isolated_i,
  input  logic                   err_clr_i,
  output logic [NumIsoPorts-1:0] isolate_o,
  output logic                   clk_ena_o,
  output logic                   reset_no,
  output logic                   link_up_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned MaxCycles = (ResetCycles > TimeoutCycles) ? ResetCycles : TimeoutCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] RstLoad = CntW'(ResetCycles - 1);
  localparam logic [CntW-1:0] ToLoad  = CntW'(TimeoutCycles - 1);

  pwr_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  pwr_ctrl_t       ctrl_q, ctrl_d;
  logic            link_up_q, busy_q;
  logic            to_hit, cnt_zero, all_iso, none_iso;

  assign cnt_zero = (cnt_q == '0);
  assign all_iso  = &isolated_i;
  assign none_iso = ~|isolated_i;

  // A handshake met in the same cycle the counter hits zero takes priority.
  always_comb begin
    state_d = state_q;
    to_hit  = 1'b0;
    unique case (state_q)
      DOWN:       if (link_up_req_i) state_d = CLK_ON;
      CLK_ON:     if (cnt_zero) state_d = RST_REL;
      RST_REL:    state_d = DEISO;
      DEISO: begin
        if (none_iso) begin
          state_d = UP;
        end else if (cnt_zero) begin
          state_d = ISO;
          to_hit  = 1'b1;
        end
      end
      UP:         if (!link_up_req_i) state_d = ISO;
      ISO: begin
        if (all_iso) begin
          state_d = RST_ASSERT;
        end else if (cnt_zero) begin
          state_d = RST_ASSERT;
          to_hit  = 1'b1;
        end
      end
      RST_ASSERT: if (cnt_zero) state_d = DOWN;
      default:    state_d = DOWN;
    endcase
  end

  // Shared down-counter, reloaded on entry to every timed state.
  always_comb begin
    cnt_d = cnt_zero ? cnt_q : cnt_q - CntW'(1);
    if (state_d != state_q) begin
      unique case (state_d)
        CLK_ON, RST_ASSERT: cnt_d = RstLoad;
        DEISO, ISO:         cnt_d = ToLoad;
        default:            cnt_d = cnt_q;
      endcase
    end
  end

  assign timeout_d = to_hit | (timeout_q & ~err_clr_i);
  assign ctrl_d    = pwr_decode(state_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DOWN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ctrl_q    <= '{isolate: 1'b1, clk_ena: 1'b0, reset_n: 1'b0};
      link_up_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ctrl_q    <= ctrl_d;
      link_up_q <= (state_d == UP);
      busy_q    <= (state_d != DOWN) && (state_d != UP);
    end
  end

  assign isolate_o = {NumIsoPorts{ctrl_q.isolate}};
  assign clk_ena_o = ctrl_q.clk_ena;
  assign reset_no  = ctrl_q.reset_n;
  assign link_up_o = link_up_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
